rfphoenix_branch_resolve: RTL and testbench

Branch resolution stage that sits directly downstream of the branch condition evaluator. It registers each branch's evaluated taken bit together with the fetch-time prediction and decides whether the prediction was correct. On a mispredict it issues a thread-tagged redirect to fetch through a valid/ready handshake and flushes that thread's wrong-path branches until the redirect is accepted. It also emits a one-cycle predictor-update pulse and maintains branch and mispredict counters.

---
 rtl/rfphoenix_branch_resolve_if.sv | 38 +++
 rtl/rfphoenix_branch_resolve.sv | 75 +++++++
 tb/tb_rfphoenix_branch_resolve.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/rfphoenix_branch_resolve_if.sv
// rfphoenix_branch_resolve_if: branch-in, redirect, flush, predictor-update and counter signals of the resolve stage
interface rfphoenix_branch_resolve_if #(
    parameter int PCW  = 32,
    parameter int TIDW = 2
);
    logic            in_valid_i;
    logic            in_ready_o;
    logic [TIDW-1:0] in_tid_i;
    logic [PCW-1:0]  in_pc_i;
    logic            in_takb_i;
    logic [PCW-1:0]  in_tgt_i;
    logic            in_pred_taken_i;
    logic [PCW-1:0]  in_pred_tgt_i;
    logic            redir_valid_o;
    logic            redir_ready_i;
    logic [TIDW-1:0] redir_tid_o;
    logic [PCW-1:0]  redir_pc_o;
    logic            flush_o;
    logic [TIDW-1:0] flush_tid_o;
    logic            upd_valid_o;
    logic [PCW-1:0]  upd_pc_o;
    logic            upd_taken_o;
    logic [PCW-1:0]  upd_tgt_o;
    logic [31:0]     br_cnt_o;
    logic [31:0]     mis_cnt_o;

    modport master (
        output in_valid_i, in_tid_i, in_pc_i, in_takb_i, in_tgt_i, in_pred_taken_i, in_pred_tgt_i, redir_ready_i,
        input  in_ready_o, redir_valid_o, redir_tid_o, redir_pc_o, flush_o, flush_tid_o,
               upd_valid_o, upd_pc_o, upd_taken_o, upd_tgt_o, br_cnt_o, mis_cnt_o
    );

    modport slave (
        input  in_valid_i, in_tid_i, in_pc_i, in_takb_i, in_tgt_i, in_pred_taken_i, in_pred_tgt_i, redir_ready_i,
        output in_ready_o, redir_valid_o, redir_tid_o, redir_pc_o, flush_o, flush_tid_o,
               upd_valid_o, upd_pc_o, upd_taken_o, upd_tgt_o, br_cnt_o, mis_cnt_o
    );
endinterface

// File: rtl/rfphoenix_branch_resolve.sv
// rfphoenix_branch_resolve: checks branch predictions, issues thread-tagged redirects and squashes wrong-path branches
module rfphoenix_branch_resolve #(
    parameter int PCW  = 32,
    parameter int TIDW = 2,
    parameter int ILEN = 5
) (
    input logic clk,
    input logic rst_n,
    rfphoenix_branch_resolve_if.slave br
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] REDIR = 1'b1;
    localparam int NTH = 2 ** TIDW;

    logic [0:0]     state;
    logic [NTH-1:0] shadow;
    logic [NTH-1:0] shadow_nxt;
    logic           acc;
    logic           hs;
    logic           good;
    logic           mis;
    logic           misp;
    logic [PCW-1:0] actual;

    assign br.in_ready_o    = (state == IDLE) || br.redir_ready_i;
    assign br.redir_valid_o = (state == REDIR);
    assign acc    = br.in_valid_i && br.in_ready_o;
    assign hs     = (state == REDIR) && br.redir_ready_i;
    assign good   = acc && !shadow[br.in_tid_i];
    assign actual = br.in_takb_i ? br.in_tgt_i : br.in_pc_i + PCW'(ILEN);
    assign mis    = (br.in_takb_i != br.in_pred_taken_i) || (br.in_takb_i && br.in_tgt_i != br.in_pred_tgt_i);
    assign misp   = good && mis;

    // shadow bits: the sampled value decides squash; clear on handshake, then set on a new mispredict
    always_comb begin
        shadow_nxt = shadow;
        if (hs) shadow_nxt[br.redir_tid_o] = 1'b0;
        if (misp) shadow_nxt[br.in_tid_i] = 1'b1;
    end

    // state, shadow, redirect/flush/update payloads and counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            shadow         <= '0;
            br.redir_tid_o <= '0;
            br.redir_pc_o  <= '0;
            br.flush_o     <= 1'b0;
            br.flush_tid_o <= '0;
            br.upd_valid_o <= 1'b0;
            br.upd_pc_o    <= '0;
            br.upd_taken_o <= 1'b0;
            br.upd_tgt_o   <= '0;
            br.br_cnt_o    <= '0;
            br.mis_cnt_o   <= '0;
        end else begin
            state          <= misp ? REDIR : (hs ? IDLE : state);
            shadow         <= shadow_nxt;
            br.flush_o     <= misp;
            br.upd_valid_o <= good;
            if (misp) begin
                br.redir_tid_o <= br.in_tid_i;
                br.redir_pc_o  <= actual;
                br.flush_tid_o <= br.in_tid_i;
                br.mis_cnt_o   <= br.mis_cnt_o + 32'd1;
            end
            if (good) begin
                br.upd_pc_o    <= br.in_pc_i;
                br.upd_taken_o <= br.in_takb_i;
                br.upd_tgt_o   <= br.in_tgt_i;
                br.br_cnt_o    <= br.br_cnt_o + 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_rfphoenix_branch_resolve.sv
// tb_rfphoenix_branch_resolve: directed vector table plus hand-written redirect/squash/reset sequences
module tb_rfphoenix_branch_resolve;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cmp_cnt = 0;
    int   err_cnt = 0;
    int   exp_br = 0;
    int   exp_mis = 0;

    typedef struct {
        logic [1:0]  tid;
        logic [31:0] pc;
        logic        takb;
        logic [31:0] tgt;
        logic        pt;
        logic [31:0] ptgt;
        logic        exp_mis;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vt[8];

    rfphoenix_branch_resolve_if #(.PCW(32), .TIDW(2)) bi ();

    rfphoenix_branch_resolve #(.PCW(32), .TIDW(2), .ILEN(5)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .br(bi.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] tid, input logic [31:0] pc, input logic takb,
                         input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt);
        bi.in_valid_i      = 1'b1;
        bi.in_tid_i        = tid;
        bi.in_pc_i         = pc;
        bi.in_takb_i       = takb;
        bi.in_tgt_i        = tgt;
        bi.in_pred_taken_i = pt;
        bi.in_pred_tgt_i   = ptgt;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        bi.in_valid_i = 1'b0;
    endtask

    initial begin
        vt[0] = '{2'd0, 32'h1000, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0};
        vt[1] = '{2'd1, 32'h1000, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1, 32'h1005};
        vt[2] = '{2'd0, 32'h1800, 1'b1, 32'h2000, 1'b1, 32'h2400, 1'b1, 32'h2000};
        vt[3] = '{2'd0, 32'h1800, 1'b1, 32'h2000, 1'b1, 32'h2000, 1'b0, 32'h0};
        vt[4] = '{2'd2, 32'h0abc, 1'b1, 32'h3000, 1'b0, 32'h0, 1'b1, 32'h3000};
        vt[5] = '{2'd3, 32'h0500, 1'b0, 32'h0777, 1'b0, 32'h5555, 1'b0, 32'h0};
        vt[6] = '{2'd1, 32'hffff_fffd, 1'b0, 32'h0, 1'b1, 32'h10, 1'b1, 32'h2};
        vt[7] = '{2'd3, 32'h0020, 1'b1, 32'h0040, 1'b1, 32'h0040, 1'b0, 32'h0};

        bi.in_valid_i = 1'b0;
        bi.redir_ready_i = 1'b0;
        drive(2'd0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        bi.in_valid_i = 1'b0;
        #11;
        chk("rst_in_ready", bi.in_ready_o, 1);
        chk("rst_redir_valid", bi.redir_valid_o, 0);
        chk("rst_upd_valid", bi.upd_valid_o, 0);
        chk("rst_flush", bi.flush_o, 0);
        chk("rst_br_cnt", bi.br_cnt_o, 0);
        chk("rst_mis_cnt", bi.mis_cnt_o, 0);
        #1 rst_n = 1'b1;
        step();

        for (int i = 0; i < 8; i++) begin
            drive(vt[i].tid, vt[i].pc, vt[i].takb, vt[i].tgt, vt[i].pt, vt[i].ptgt);
            step();
            exp_br++;
            if (vt[i].exp_mis) exp_mis++;
            chk($sformatf("v%0d_upd_valid", i), bi.upd_valid_o, 1);
            chk($sformatf("v%0d_upd_pc", i), bi.upd_pc_o, vt[i].pc);
            chk($sformatf("v%0d_upd_taken", i), bi.upd_taken_o, vt[i].takb);
            chk($sformatf("v%0d_upd_tgt", i), bi.upd_tgt_o, vt[i].tgt);
            chk($sformatf("v%0d_flush", i), bi.flush_o, vt[i].exp_mis);
            chk($sformatf("v%0d_redir_valid", i), bi.redir_valid_o, vt[i].exp_mis);
            chk($sformatf("v%0d_br_cnt", i), bi.br_cnt_o, exp_br);
            chk($sformatf("v%0d_mis_cnt", i), bi.mis_cnt_o, exp_mis);
            if (vt[i].exp_mis) begin
                chk($sformatf("v%0d_redir_pc", i), bi.redir_pc_o, vt[i].exp_pc);
                chk($sformatf("v%0d_redir_tid", i), bi.redir_tid_o, vt[i].tid);
                chk($sformatf("v%0d_flush_tid", i), bi.flush_tid_o, vt[i].tid);
                bi.redir_ready_i = 1'b1;
            end
            step();
            bi.redir_ready_i = 1'b0;
            chk($sformatf("v%0d_redir_done", i), bi.redir_valid_o, 0);
            chk($sformatf("v%0d_upd_pulse", i), bi.upd_valid_o, 0);
            chk($sformatf("v%0d_flush_pulse", i), bi.flush_o, 0);
        end

        // stalled redirect holds payload and blocks input
        drive(2'd1, 32'h1000, 1'b0, 32'h0, 1'b1, 32'h0);
        step();
        exp_br++;
        exp_mis++;
        chk("stall_flush", bi.flush_o, 1);
        chk("stall_in_ready0", bi.in_ready_o, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("stall%0d_redir_valid", k), bi.redir_valid_o, 1);
            chk($sformatf("stall%0d_redir_pc", k), bi.redir_pc_o, 32'h1005);
            chk($sformatf("stall%0d_redir_tid", k), bi.redir_tid_o, 1);
            chk($sformatf("stall%0d_in_ready", k), bi.in_ready_o, 0);
            chk($sformatf("stall%0d_flush", k), bi.flush_o, 0);
        end
        bi.redir_ready_i = 1'b1;
        #1 chk("stall_in_ready1", bi.in_ready_o, 1);
        step();
        bi.redir_ready_i = 1'b0;
        chk("stall_release", bi.redir_valid_o, 0);
        drive(2'd1, 32'h1100, 1'b0, 32'h0, 1'b0, 32'h0);
        step();
        exp_br++;
        chk("stall_tid1_counted", bi.upd_valid_o, 1);
        chk("stall_br_cnt", bi.br_cnt_o, exp_br);

        // squash of same-thread branch on the handshake edge
        drive(2'd2, 32'h2000, 1'b0, 32'h0, 1'b1, 32'h0);
        step();
        exp_br++;
        exp_mis++;
        chk("sq_redir_pc", bi.redir_pc_o, 32'h2005);
        bi.redir_ready_i = 1'b1;
        drive(2'd2, 32'h2004, 1'b0, 32'h0, 1'b0, 32'h0);
        step();
        bi.redir_ready_i = 1'b0;
        chk("sq_upd_valid", bi.upd_valid_o, 0);
        chk("sq_br_cnt", bi.br_cnt_o, exp_br);
        chk("sq_redir_valid", bi.redir_valid_o, 0);
        drive(2'd2, 32'h2008, 1'b0, 32'h0, 1'b0, 32'h0);
        step();
        exp_br++;
        chk("sq_next_upd", bi.upd_valid_o, 1);
        chk("sq_next_br_cnt", bi.br_cnt_o, exp_br);
        chk("sq_mis_cnt", bi.mis_cnt_o, exp_mis);

        // back-to-back: tid0 mispredict on tid3 handshake edge
        drive(2'd3, 32'h3000, 1'b1, 32'h3100, 1'b0, 32'h0);
        step();
        exp_br++;
        exp_mis++;
        chk("b2b_tid3", bi.redir_tid_o, 3);
        bi.redir_ready_i = 1'b1;
        drive(2'd0, 32'h0100, 1'b1, 32'h0200, 1'b0, 32'h0);
        step();
        exp_br++;
        exp_mis++;
        chk("b2b_redir_valid", bi.redir_valid_o, 1);
        chk("b2b_redir_tid", bi.redir_tid_o, 0);
        chk("b2b_redir_pc", bi.redir_pc_o, 32'h0200);
        chk("b2b_flush", bi.flush_o, 1);
        chk("b2b_flush_tid", bi.flush_tid_o, 0);
        chk("b2b_mis_cnt", bi.mis_cnt_o, exp_mis);
        drive(2'd0, 32'h0104, 1'b0, 32'h0, 1'b0, 32'h0);
        step();
        chk("b2b_tid0_squashed", bi.upd_valid_o, 0);
        chk("b2b_idle", bi.redir_valid_o, 0);
        bi.redir_ready_i = 1'b0;
        drive(2'd3, 32'h3104, 1'b0, 32'h0, 1'b0, 32'h0);
        step();
        exp_br++;
        chk("b2b_tid3_counted", bi.upd_valid_o, 1);
        chk("b2b_br_cnt", bi.br_cnt_o, exp_br);

        // PC wrap then asynchronous reset mid-redirect
        drive(2'd1, 32'hffff_fffd, 1'b0, 32'h0, 1'b1, 32'h0);
        step();
        chk("wrap_redir_pc", bi.redir_pc_o, 32'h2);
        chk("wrap_redir_valid", bi.redir_valid_o, 1);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_redir_valid", bi.redir_valid_o, 0);
        chk("arst_redir_pc", bi.redir_pc_o, 0);
        chk("arst_redir_tid", bi.redir_tid_o, 0);
        chk("arst_flush", bi.flush_o, 0);
        chk("arst_upd_valid", bi.upd_valid_o, 0);
        chk("arst_upd_pc", bi.upd_pc_o, 0);
        chk("arst_br_cnt", bi.br_cnt_o, 0);
        chk("arst_mis_cnt", bi.mis_cnt_o, 0);
        chk("arst_in_ready", bi.in_ready_o, 1);
        #2 rst_n = 1'b1;
        step();
        chk("arst_dropped", bi.redir_valid_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule
